// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor:
//   - STATE_W          : width of the supervisor state encoding
//   - pll_sup_state_e  : supervisor FSM states
//   - max_int()        : elaboration-time helper used to size internal counters
// -----------------------------------------------------------------------------
package pll_sup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } pll_sup_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_sup_sync2.sv
// -----------------------------------------------------------------------------
// pll_sup_sync2
// Two-flop synchroniser bringing the asynchronous PLL locked flag into the
// supervisor clock domain. Both flops clear to 0 under reset.
// Ports:
//   clk : destination clock
//   rst : synchronous reset, active-low
//   d   : asynchronous input
//   q   : synchronised output (2 cycles latency)
// The first flop is the only one allowed to go metastable; it carries the
// ASYNC_REG attribute so implementation keeps both flops adjacent and the
// path into it is treated as a false path.
// -----------------------------------------------------------------------------
module pll_sup_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;

  // NOTE: registered state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Drives the PLL reset, qualifies the PLL locked flag (synchroniser plus
// stability window), releases the per-clock domain resets one by one in index
// order and recovers automatically from lock loss, lock timeout or a relock
// request.
// Ports:
//   refclk        : supervisor clock (PLL reference clock)
//   rst           : synchronous reset, active-low
//   pll_locked    : PLL locked flag, asynchronous to refclk
//   force_relock  : single-cycle request to reset the PLL again
//   pll_rst       : PLL reset, active-high
//   clk_rst_n     : per-domain resets, active-low, released bit 0 first
//   ready         : all domains released and PLL locked
//   lock_loss_cnt : saturating count of lock losses seen in RUN
//   timeout_cnt   : saturating count of lock timeouts in WAIT_LOCK
//   state         : current FSM state (debug)
// Build option:
//   PLL_LOCK_SUP_TIMEOUT_EN : when defined, WAIT_LOCK gives up after
//   RELOCK_TIMEOUT cycles and re-resets the PLL; when undefined it waits
//   forever and timeout_cnt is tied to 0.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_CLKS           = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SEQ_GAP_CYCLES     = 8,
  parameter int RELOCK_TIMEOUT     = 1048576,
  parameter int CNT_W              = 8
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                force_relock,
  output logic                pll_rst,
  output logic [NUM_CLKS-1:0] clk_rst_n,
  output logic                ready,
  output logic [CNT_W-1:0]    lock_loss_cnt,
  output logic [CNT_W-1:0]    timeout_cnt,
  output logic [STATE_W-1:0]  state
);

  // One shared cycle counter serves every state; only one state counts at a
  // time and it is cleared on every state change.
  localparam int CNT_MAX = max_int(max_int(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                   max_int(SEQ_GAP_CYCLES, RELOCK_TIMEOUT));
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]       RST_LAST = CW'(PLL_RST_CYCLES);
  localparam logic [CW-1:0]       STB_LAST = CW'(LOCK_STABLE_CYCLES);
  localparam logic [CW-1:0]       GAP_LAST = CW'(SEQ_GAP_CYCLES);
  localparam logic [NUM_CLKS-1:0] ALL_ON   = '1;
  localparam logic [NUM_CLKS-1:0] LSB      = NUM_CLKS'(1);

  pll_sup_state_e      state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [NUM_CLKS-1:0] crn_q, crn_d;
  logic                pll_rst_q, ready_q;
  logic [CNT_W-1:0]    loss_q;
  logic                loss_inc;
  logic                lk_s;

`ifdef PLL_LOCK_SUP_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(RELOCK_TIMEOUT);
  logic                     to_inc;
  logic [CNT_W-1:0]         to_q;
`endif

  pll_sup_sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk_s)
  );

  assign cnt_inc = cnt_q + CW'(1);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crn_d    = crn_q;
    loss_inc = 1'b0;
`ifdef PLL_LOCK_SUP_TIMEOUT_EN
    to_inc   = 1'b0;
`endif

    case (state_q)
      RESET_PLL: begin
        // A relock request here stretches the pulse back to full length.
        if (force_relock)            cnt_d   = '0;
        else if (cnt_inc == RST_LAST) state_d = WAIT_LOCK;
        else                         cnt_d   = cnt_inc;
      end

      WAIT_LOCK: begin
        if (force_relock) state_d = RESET_PLL;
        else if (lk_s)    state_d = STABLE;
`ifdef PLL_LOCK_SUP_TIMEOUT_EN
        else if (cnt_inc == TO_LAST) begin
          state_d = RESET_PLL;
          to_inc  = 1'b1;
        end
        else cnt_d = cnt_inc;
`endif
      end

      STABLE: begin
        if (force_relock)             state_d = RESET_PLL;
        else if (!lk_s)               state_d = WAIT_LOCK;
        else if (cnt_inc == STB_LAST) state_d = RELEASE;
        else                          cnt_d   = cnt_inc;
      end

      RELEASE: begin
        // clk_rst_n fills as a thermometer code from bit 0; the first bit goes
        // immediately, each later bit SEQ_GAP_CYCLES after its predecessor.
        if (force_relock || !lk_s) state_d = RESET_PLL;
        else if (crn_q == ALL_ON)  state_d = RUN;
        else if (crn_q == '0 || cnt_inc == GAP_LAST) begin
          crn_d = (crn_q << 1) | LSB;
          cnt_d = '0;
        end
        else cnt_d = cnt_inc;
      end

      RUN: begin
        // Lock loss is checked first so a coincident relock request still
        // counts the loss exactly once.
        if (!lk_s) begin
          state_d  = RESET_PLL;
          loss_inc = 1'b1;
        end
        else if (force_relock) state_d = RESET_PLL;
      end

      default: state_d = RESET_PLL;
    endcase

    if (state_d != state_q)   cnt_d = '0;
    if (state_d == RESET_PLL) crn_d = '0;
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      crn_q     <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crn_q     <= crn_d;
      pll_rst_q <= (state_d == RESET_PLL);
      ready_q   <= (state_d == RUN);
      if (loss_inc && loss_q != '1) loss_q <= loss_q + CNT_W'(1);
    end
  end

`ifdef PLL_LOCK_SUP_TIMEOUT_EN
  always_ff @(posedge refclk) begin
    if (!rst)                      to_q <= '0;
    else if (to_inc && to_q != '1) to_q <= to_q + CNT_W'(1);
  end
  assign timeout_cnt = to_q;
`else
  assign timeout_cnt = '0;
`endif

  assign pll_rst       = pll_rst_q;
  assign clk_rst_n     = crn_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;

endmodule
